// File: rtl/la_oa33_arb_if.sv
// Handshake bundle for the la_oa33_arb rendezvous arbiter.
//   a_req/b_req : group A / group B request vectors (bit i = requester i)
//   done        : transfer complete from the shared channel
//   a_gnt/b_gnt : one-hot grants, all zero when idle
//   busy        : high while a pairing is granted
//   tmo         : one-cycle pulse when a grant is aborted by timeout
// master drives requests/done; slave is the arbiter.
interface la_oa33_arb_if;
  logic [2:0] a_req;
  logic [2:0] b_req;
  logic       done;
  logic [2:0] a_gnt;
  logic [2:0] b_gnt;
  logic       busy;
  logic       tmo;

  modport master (
    output a_req, b_req, done,
    input  a_gnt, b_gnt, busy, tmo
  );

  modport slave (
    input  a_req, b_req, done,
    output a_gnt, b_gnt, busy, tmo
  );
endinterface

// File: rtl/la_oa33_arb.sv
// Rendezvous arbiter: pairs one of three group-A requesters with one of
// three group-B requesters when (|a_req) & (|b_req). Each side is picked
// round-robin; both grants are held until done or until TIMEOUT cycles
// elapse (TIMEOUT=0 disables the timeout). All outputs are registered.
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : la_oa33_arb_if.slave (a_req, b_req, done in; a_gnt, b_gnt,
//           busy, tmo out)
module la_oa33_arb #(
  parameter              PROP    = "DEFAULT",
  parameter int unsigned TIMEOUT = 8
) (
  input  logic               clk,
  input  logic               reset,
  la_oa33_arb_if.slave       bus
);

  localparam int unsigned   CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TMO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam int unsigned   UnusedPropBits = $bits(PROP);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t        state_q;
  logic [1:0]    a_ptr_q, b_ptr_q;
  logic [1:0]    a_ptr_d, b_ptr_d;
  logic [2:0]    a_gnt_q, b_gnt_q;
  logic [2:0]    a_gnt_d, b_gnt_d;
  logic          busy_q, tmo_q;
  logic [CW-1:0] count_q;
  logic          match;

  function automatic logic [1:0] inc3(input logic [1:0] x);
    return (x == 2'd2) ? 2'd0 : x + 2'd1;
  endfunction

  // First asserted request scanning ptr, ptr+1, ptr+2 (mod 3).
  function automatic logic [1:0] rr_pick(input logic [2:0] req,
                                         input logic [1:0] ptr);
    logic [1:0] c0, c1, c2;
    c0 = ptr;
    c1 = inc3(c0);
    c2 = inc3(c1);
    if (req[c0])      return c0;
    else if (req[c1]) return c1;
    else              return c2;
  endfunction

  always_comb begin
    logic [1:0] a_win, b_win;
    a_win   = rr_pick(bus.a_req, a_ptr_q);
    b_win   = rr_pick(bus.b_req, b_ptr_q);
    a_gnt_d = 3'b001 << a_win;
    b_gnt_d = 3'b001 << b_win;
    a_ptr_d = inc3(a_win);
    b_ptr_d = inc3(b_win);
    match   = (|bus.a_req) & (|bus.b_req);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      a_ptr_q <= '0;
      b_ptr_q <= '0;
      a_gnt_q <= '0;
      b_gnt_q <= '0;
      busy_q  <= 1'b0;
      tmo_q   <= 1'b0;
      count_q <= '0;
    end else begin
      tmo_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (match) begin
            a_gnt_q <= a_gnt_d;
            b_gnt_q <= b_gnt_d;
            a_ptr_q <= a_ptr_d;
            b_ptr_q <= b_ptr_d;
            busy_q  <= 1'b1;
            count_q <= '0;
            state_q <= GRANT;
          end
        end
        GRANT: begin
          // done has priority over a simultaneous timeout expiry.
          if (bus.done) begin
            a_gnt_q <= '0;
            b_gnt_q <= '0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if ((TIMEOUT > 0) && (count_q == TMO_LAST)) begin
            a_gnt_q <= '0;
            b_gnt_q <= '0;
            busy_q  <= 1'b0;
            tmo_q   <= 1'b1;
            state_q <= IDLE;
          end else if (TIMEOUT > 0) begin
            count_q <= count_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.a_gnt = a_gnt_q;
  assign bus.b_gnt = b_gnt_q;
  assign bus.busy  = busy_q;
  assign bus.tmo   = tmo_q;

endmodule

// File: tb/tb_la_oa33_arb.sv
module tb_la_oa33_arb;
  localparam int TMO = 8;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  la_oa33_arb_if bus ();

  la_oa33_arb #(.PROP("DEFAULT"), .TIMEOUT(TMO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural reference: grant held as winner indices plus an age counter
  // (number of cycles the grant has been visible).
  bit m_busy, m_tmo;
  int m_ai, m_bi, m_aptr, m_bptr, m_age;

  function automatic int pick(input logic [2:0] req, input int ptr);
    for (int k = 0; k < 3; k++) begin
      int idx;
      idx = (ptr + k) % 3;
      if (req[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_tmo = 0; m_ai = 0; m_bi = 0;
    m_aptr = 0; m_bptr = 0; m_age = 0;
  endtask

  task automatic model_edge(input logic [2:0] a, input logic [2:0] b,
                            input logic d);
    m_tmo = 0;
    if (!m_busy) begin
      if (a != 0 && b != 0) begin
        m_ai = pick(a, m_aptr);
        m_bi = pick(b, m_bptr);
        m_aptr = (m_ai + 1) % 3;
        m_bptr = (m_bi + 1) % 3;
        m_busy = 1;
        m_age = 1;
      end
    end else begin
      if (d) m_busy = 0;
      else if (TMO > 0 && m_age == TMO) begin
        m_busy = 0;
        m_tmo = 1;
      end else m_age++;
    end
  endtask

  task automatic chk(input string nm, input logic [7:0] act,
                     input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_model(input string tag);
    logic [2:0] ea, eb;
    ea = m_busy ? (3'b001 << m_ai) : 3'b000;
    eb = m_busy ? (3'b001 << m_bi) : 3'b000;
    chk({tag, ".a_gnt"}, {5'd0, bus.a_gnt}, {5'd0, ea});
    chk({tag, ".b_gnt"}, {5'd0, bus.b_gnt}, {5'd0, eb});
    chk({tag, ".busy"},  {7'd0, bus.busy},  {7'd0, m_busy});
    chk({tag, ".tmo"},   {7'd0, bus.tmo},   {7'd0, m_tmo});
  endtask

  // One clock: model consumes the inputs present at the edge, then the DUT
  // outputs are sampled 1 time unit later.
  task automatic tick(input string tag);
    @(posedge clk);
    model_edge(bus.a_req, bus.b_req, bus.done);
    #1;
    chk_model(tag);
  endtask

  task automatic drive(input logic [2:0] a, input logic [2:0] b,
                       input logic d);
    bus.a_req = a;
    bus.b_req = b;
    bus.done  = d;
  endtask

  typedef struct {
    logic [2:0] a, b;
    logic       d;
    logic [2:0] ea, eb;
    logic       ebusy, etmo;
  } vec_t;

  vec_t vt[13];
  int   busy_cnt, tmo_cnt;

  initial begin
    checks = 0;
    failures = 0;

    vt[0]  = '{3'b111, 3'b111, 1'b0, 3'b001, 3'b001, 1'b1, 1'b0};
    vt[1]  = '{3'b111, 3'b111, 1'b0, 3'b001, 3'b001, 1'b1, 1'b0};
    vt[2]  = '{3'b000, 3'b111, 1'b1, 3'b000, 3'b000, 1'b0, 1'b0};
    vt[3]  = '{3'b111, 3'b111, 1'b0, 3'b010, 3'b010, 1'b1, 1'b0};
    vt[4]  = '{3'b111, 3'b111, 1'b1, 3'b000, 3'b000, 1'b0, 1'b0};
    vt[5]  = '{3'b111, 3'b111, 1'b0, 3'b100, 3'b100, 1'b1, 1'b0};
    vt[6]  = '{3'b111, 3'b111, 1'b1, 3'b000, 3'b000, 1'b0, 1'b0};
    vt[7]  = '{3'b111, 3'b111, 1'b0, 3'b001, 3'b001, 1'b1, 1'b0};
    vt[8]  = '{3'b000, 3'b000, 1'b1, 3'b000, 3'b000, 1'b0, 1'b0};
    vt[9]  = '{3'b101, 3'b000, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0};
    vt[10] = '{3'b101, 3'b000, 1'b1, 3'b000, 3'b000, 1'b0, 1'b0};
    vt[11] = '{3'b101, 3'b010, 1'b0, 3'b100, 3'b010, 1'b1, 1'b0};
    vt[12] = '{3'b000, 3'b000, 1'b1, 3'b000, 3'b000, 1'b0, 1'b0};

    // Reset with all requests asserted: nothing granted.
    reset = 1'b1;
    drive(3'b111, 3'b111, 1'b0);
    model_reset();
    @(posedge clk); #1;
    chk_model("reset");
    @(posedge clk); #1;
    reset = 1'b0;

    // Directed table from reset.
    for (int i = 0; i < 13; i++) begin
      drive(vt[i].a, vt[i].b, vt[i].d);
      tick($sformatf("vec%0d", i));
      chk($sformatf("vec%0d.tab_a", i), {5'd0, bus.a_gnt}, {5'd0, vt[i].ea});
      chk($sformatf("vec%0d.tab_b", i), {5'd0, bus.b_gnt}, {5'd0, vt[i].eb});
      chk($sformatf("vec%0d.tab_busy", i), {7'd0, bus.busy}, {7'd0, vt[i].ebusy});
      chk($sformatf("vec%0d.tab_tmo", i), {7'd0, bus.tmo}, {7'd0, vt[i].etmo});
    end

    // One-sided requests held for 10 cycles never grant.
    drive(3'b101, 3'b000, 1'b0);
    for (int i = 0; i < 10; i++) tick("onesided");
    chk("onesided.busy", {7'd0, bus.busy}, 8'd0);

    // Timeout: grant held exactly TMO cycles, one tmo pulse, then re-grant.
    drive(3'b111, 3'b111, 1'b0);
    busy_cnt = 0;
    tmo_cnt = 0;
    for (int i = 0; i < TMO + 2; i++) begin
      tick("timeout");
      if (bus.busy) busy_cnt++;
      if (bus.tmo) tmo_cnt++;
    end
    chk("timeout.busy_cycles", 8'(busy_cnt), 8'(TMO + 1));
    chk("timeout.tmo_pulses", 8'(tmo_cnt), 8'd1);
    drive(3'b000, 3'b000, 1'b1);
    tick("timeout.end");
    chk("timeout.idle", {7'd0, bus.busy}, 8'd0);

    // Collision: done on the last cycle before expiry wins, no tmo.
    drive(3'b111, 3'b111, 1'b0);
    tick("coll.grant");
    for (int i = 0; i < TMO - 1; i++) tick("coll.hold");
    chk("coll.still_busy", {7'd0, bus.busy}, 8'd1);
    drive(3'b111, 3'b111, 1'b1);
    tick("coll.edge");
    chk("coll.busy", {7'd0, bus.busy}, 8'd0);
    chk("coll.tmo", {7'd0, bus.tmo}, 8'd0);
    drive(3'b000, 3'b000, 1'b0);
    tick("coll.idle");

    // Requests vanishing mid-grant do not drop the grant.
    drive(3'b111, 3'b111, 1'b0);
    tick("mid.grant");
    drive(3'b000, 3'b000, 1'b0);
    tick("mid.hold1");
    tick("mid.hold2");
    chk("mid.held", {7'd0, bus.busy}, 8'd1);

    // Asynchronous reset mid-grant clears outputs before any clock edge.
    reset = 1'b1;
    #2;
    model_reset();
    chk_model("async_reset");
    @(posedge clk); #1;
    reset = 1'b0;
    drive(3'b111, 3'b111, 1'b0);
    tick("post_reset");
    chk("post_reset.a", {5'd0, bus.a_gnt}, 8'b001);
    drive(3'b000, 3'b000, 1'b1);
    tick("post_reset.done");

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      drive(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
            1'($urandom_range(0, 5) == 0));
      tick("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
